// File: rtl/hpdcache_pkg.sv
// Shared types and helpers for the HPDcache memory response path.
// The response ID field width here must match the ID_WIDTH used by its consumers.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 8;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_resp_r_id;
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
  } hpdcache_mem_resp_r_t;

  // Occupancy encoding: bit 0 is the head valid, bit 1 the spare valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } hpdcache_occ_e;

  function automatic int unsigned hpdcache_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requester index taken from the top idx_w bits of an id_width-bit ID.
  function automatic logic [3:0] hpdcache_resp_idx(input logic [31:0] id,
                                                   input int unsigned id_width,
                                                   input int unsigned idx_w);
    logic [31:0] shifted;
    shifted = id >> (id_width - idx_w);
    return 4'(shifted & ((32'd1 << idx_w) - 32'd1));
  endfunction

endpackage

// File: rtl/hpdcache_skid_buf.sv
// Generic 2-entry skid buffer: head register plus spare register.
// The input ready is a plain state bit, so it has no path from out_ready.
module hpdcache_skid_buf
  import hpdcache_pkg::*;
#(
  parameter type data_t = logic [31:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data
);

  hpdcache_occ_e state, next_state;
  data_t         head, spare;
  logic          accept, pop, load_head, load_spare, shift_spare;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign out_data  = head;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCC_EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load_head   = 1'b0;
    load_spare  = 1'b0;
    shift_spare = 1'b0;
    unique case (state)
      OCC_EMPTY: begin
        if (accept) begin
          next_state = OCC_ONE;
          load_head  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          next_state = OCC_TWO;
          load_spare = 1'b1;
        end else if (pop) begin
          next_state = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          next_state  = OCC_ONE;
          shift_spare = 1'b1;
        end
      end
      default: next_state = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      spare <= '0;
    end else begin
      if (load_head)        head <= in_data;
      else if (shift_spare) head <= spare;
      if (load_spare)       spare <= in_data;
    end
  end

endmodule

// File: rtl/hpdcache_mem_resp_read_demux.sv
// Steers memory read responses to requester k taken from the ID MSBs.
// Strict arrival order is kept; responses with an unmapped index are dropped and counted.
module hpdcache_mem_resp_read_demux #(
  parameter int unsigned N        = 4,
  parameter int unsigned ID_WIDTH = 8,
  parameter type hpdcache_mem_resp_r_t = hpdcache_pkg::hpdcache_mem_resp_r_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 mem_resp_read_ready_o,
  input  logic                 mem_resp_read_valid_i,
  input  hpdcache_mem_resp_r_t mem_resp_read_i,
  input  logic [N-1:0]         mem_resp_read_ready_i,
  output logic [N-1:0]         mem_resp_read_valid_o,
  output hpdcache_mem_resp_r_t mem_resp_read_o [N-1:0],
  output logic                 unmapped_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int unsigned IDX_W = hpdcache_pkg::hpdcache_idx_width(N);

  // Index and mapped flag are decoded on the way in so the outputs are register-driven.
  typedef struct packed {
    hpdcache_mem_resp_r_t resp;
    logic [IDX_W-1:0]     idx;
    logic                 mapped;
  } entry_t;

  entry_t           in_entry, head;
  logic [IDX_W-1:0] in_idx;
  logic             head_valid, head_ready;

  always_comb begin
    in_idx          = IDX_W'(hpdcache_pkg::hpdcache_resp_idx(32'(mem_resp_read_i.mem_resp_r_id),
                                                             ID_WIDTH, IDX_W));
    in_entry.resp   = mem_resp_read_i;
    in_entry.idx    = in_idx;
    in_entry.mapped = (32'(in_idx) < N);
  end

  hpdcache_skid_buf #(
    .data_t (entry_t)
  ) i_skid_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (mem_resp_read_valid_i),
    .in_ready  (mem_resp_read_ready_o),
    .in_data   (in_entry),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head)
  );

  // An unmapped head never waits on a requester, so it drains in one cycle.
  assign head_ready = head.mapped ? mem_resp_read_ready_i[head.idx] : 1'b1;
  assign unmapped_o = head_valid & ~head.mapped;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign mem_resp_read_valid_o[i] = head_valid & head.mapped & (head.idx == IDX_W'(i));
    assign mem_resp_read_o[i]       = head.resp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                drop_cnt_o <= '0;
    else if (unmapped_o && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
  end

endmodule

// File: tb/tb_hpdcache_mem_resp_read_demux.sv
// Scoreboard bench for the read response demux, one N=4 and one N=3 instance.
// The model treats the buffer as an ordered list of at most two pending responses.
module tb_hpdcache_mem_resp_read_demux;
  import hpdcache_pkg::*;

  typedef hpdcache_mem_resp_r_t resp_t;
  typedef struct {
    int    idx;
    bit    mapped;
    resp_t resp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       v4 = 1'b0, v3 = 1'b0;
  resp_t      in4 = '0, in3 = '0;
  logic [3:0] rdy4 = 4'hF;
  logic [2:0] rdy3 = 3'h7;
  logic       ready_o4, ready_o3, unm4, unm3;
  logic [3:0] vo4;
  logic [2:0] vo3;
  logic [7:0] cnt4, cnt3;
  resp_t      out4 [3:0];
  resp_t      out3 [2:0];

  exp_t exp_q [2][$];
  int   drops [2];
  int   n_checks = 0;
  int   n_pass   = 0;

  hpdcache_mem_resp_read_demux #(.N(4), .ID_WIDTH(8)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .mem_resp_read_ready_o(ready_o4), .mem_resp_read_valid_i(v4), .mem_resp_read_i(in4),
    .mem_resp_read_ready_i(rdy4), .mem_resp_read_valid_o(vo4), .mem_resp_read_o(out4),
    .unmapped_o(unm4), .drop_cnt_o(cnt4)
  );

  hpdcache_mem_resp_read_demux #(.N(3), .ID_WIDTH(8)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .mem_resp_read_ready_o(ready_o3), .mem_resp_read_valid_i(v3), .mem_resp_read_i(in3),
    .mem_resp_read_ready_i(rdy3), .mem_resp_read_valid_o(vo3), .mem_resp_read_o(out3),
    .unmapped_o(unm3), .drop_cnt_o(cnt3)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Requester index is the top two ID bits for both instances (IDX_W = 2).
  function automatic exp_t mk(input resp_t r, input int n);
    exp_t e;
    e.idx    = int'(r.mem_resp_r_id) / 64;
    e.mapped = (e.idx < n);
    e.resp   = r;
    return e;
  endfunction

  task automatic checkOutput(input int inst, input int n, input logic vin, input resp_t din,
                             input logic [3:0] rdy, input logic rdy_o, input logic [3:0] vo,
                             input resp_t dout [3:0], input logic unm, input logic [7:0] cnt);
    exp_t       h;
    bit         have, pop, acc;
    logic [3:0] ev;
    if (rst) begin
      exp_q[inst].delete();
      drops[inst] = 0;
      check($sformatf("rst_ready_o%0d", inst), rdy_o, 1);
      check($sformatf("rst_valid_o%0d", inst), vo, 0);
      check($sformatf("rst_unmapped%0d", inst), unm, 0);
      check($sformatf("rst_drop_cnt%0d", inst), cnt, 0);
      return;
    end
    have = exp_q[inst].size() > 0;
    if (have) h = exp_q[inst][0];
    ev = (have && h.mapped) ? 4'(1 << h.idx) : 4'd0;
    check($sformatf("ready_o%0d", inst), rdy_o, exp_q[inst].size() < 2);
    check($sformatf("valid_o%0d", inst), vo, ev);
    check($sformatf("onehot%0d", inst), $countones(vo) <= 1, 1);
    check($sformatf("unmapped%0d", inst), unm, have && !h.mapped);
    check($sformatf("drop_cnt%0d", inst), cnt, drops[inst]);
    if (have && h.mapped) check($sformatf("payload%0d", inst), 64'(dout[h.idx]), 64'(h.resp));
    // Advance the model by what the coming clock edge does.
    acc = vin && (exp_q[inst].size() < 2);
    pop = have && (!h.mapped || rdy[h.idx]);
    if (pop) begin
      void'(exp_q[inst].pop_front());
      if (!h.mapped && drops[inst] < 255) drops[inst]++;
    end
    if (acc) exp_q[inst].push_back(mk(din, n));
  endtask

  always @(negedge clk) begin
    resp_t d3 [3:0];
    d3[0] = out3[0];
    d3[1] = out3[1];
    d3[2] = out3[2];
    d3[3] = '0;
    checkOutput(0, 4, v4, in4, rdy4, ready_o4, vo4, out4, unm4, cnt4);
    checkOutput(1, 3, v3, in3, {1'b0, rdy3}, ready_o3, {1'b0, vo3}, d3, unm3, cnt3);
  end

  // Presents one response and holds it until the DUT takes it.
  task automatic applyStimulus(input int inst, input logic [7:0] id);
    resp_t r;
    bit    took;
    took              = 1'b0;
    r.mem_resp_r_id   = id;
    r.mem_resp_r_data = $urandom;
    if (inst == 0) begin v4 = 1'b1; in4 = r; end
    else           begin v3 = 1'b1; in3 = r; end
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = (inst == 0) ? ready_o4 : ready_o3;
      @(posedge clk);
      #1;
    end
    if (inst == 0) v4 = 1'b0;
    else           v3 = 1'b0;
    check("accept_timeout", took, 1);
  endtask

  initial begin
    logic [7:0] seq [4];
    seq = '{8'h40, 8'h80, 8'hC0, 8'h00};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) applyStimulus(0, seq[i]);
    repeat (3) @(posedge clk);
    #1;

    // Requester 2 stalled: two responses fill the buffer, the third waits.
    rdy4 = 4'b1011;
    applyStimulus(0, 8'h81);
    applyStimulus(0, 8'h82);
    @(negedge clk);
    check("full_ready_o", ready_o4, 0);
    @(posedge clk);
    #1;
    fork
      applyStimulus(0, 8'h83);
      begin
        repeat (4) @(posedge clk);
        #1 rdy4 = 4'hF;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Head-of-line blocking behind a stalled requester 1.
    rdy4 = 4'b1101;
    applyStimulus(0, 8'h40);
    applyStimulus(0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("hol_valid_o", vo4, 4'b0010);
    rdy4 = 4'hF;
    repeat (3) @(posedge clk);
    #1;

    // Unmapped index 3 on the N=3 instance.
    applyStimulus(1, 8'hC0);
    check("unmapped_pulse", unm3, 1);
    check("unmapped_no_valid", vo3, 0);
    @(posedge clk);
    #1;
    check("drop_cnt_one", cnt3, 1);
    for (int i = 0; i < 300; i++) applyStimulus(1, 8'hC0 | 8'($urandom_range(0, 63)));
    repeat (3) @(posedge clk);
    #1;
    check("drop_cnt_sat", cnt3, 255);

    // Asynchronous reset while dut4 holds two responses.
    rdy4 = 4'h0;
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h40);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid_o", vo4, 0);
    check("async_rst_ready_o", ready_o4, 1);
    check("async_rst_drop_cnt", cnt3, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy4 = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("no_stale_valid", vo4, 0);

    for (int i = 0; i < 3000; i++) begin
      v4   = 1'($urandom);
      in4  = resp_t'({8'($urandom), 32'($urandom)});
      rdy4 = 4'($urandom) | 4'($urandom);
      v3   = 1'($urandom);
      in3  = resp_t'({8'($urandom), 32'($urandom)});
      rdy3 = 3'($urandom) | 3'($urandom);
      @(posedge clk);
      #1;
    end
    v4   = 1'b0;
    v3   = 1'b0;
    rdy4 = 4'hF;
    rdy3 = 3'h7;
    repeat (6) @(posedge clk);
    #1;
    check("drain_q4", exp_q[0].size(), 0);
    check("drain_q3", exp_q[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
